// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock: entry FSM states,
// BCD HH:MM field layout, reset alarm value and the legal-time check.
package alarm_clock_pkg;

   // Keypad entry FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENTRY  = 2'd1,
      ST_COMMIT = 2'd2
   } entry_state_e;

   // Which register a commit writes
   typedef enum logic {
      TGT_TIME  = 1'b0,
      TGT_ALARM = 1'b1
   } commit_target_e;

   // BCD 24-hour time, most significant digit first
   typedef struct packed {
      logic [3:0] ms_hour;
      logic [3:0] ls_hour;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

   // Default alarm at reset; nonzero so it cannot match 00:00 at reset
   localparam logic [15:0] ALARM_RESET_DEFAULT = 16'h0600;

   // True when every digit is within its range for a 24-hour HH:MM value
   function automatic logic bcd_time_legal(input bcd_time_t t);
      logic ok_v;
      ok_v = 1'b1;
      if (t.ms_hour > 4'd2) begin
         ok_v = 1'b0;
      end else if (t.ls_hour > 4'd9) begin
         ok_v = 1'b0;
      end else if ((t.ms_hour == 4'd2) && (t.ls_hour > 4'd3)) begin
         ok_v = 1'b0;
      end else if (t.ms_min > 4'd5) begin
         ok_v = 1'b0;
      end else if (t.ls_min > 4'd9) begin
         ok_v = 1'b0;
      end else begin
         ok_v = 1'b1;
      end
      return ok_v;
   endfunction

endpackage

// File: rtl/bcd_minute_inc.sv
// Combinational BCD HH:MM plus one minute, wrapping 23:59 to 00:00.
// Saturating compares keep every digit in range even on odd inputs.
module bcd_minute_inc
   import alarm_clock_pkg::*;
(
   input  logic [15:0] time_cur,
   output logic [15:0] time_next
);

   bcd_time_t cur_s;
   bcd_time_t nxt_s;

   assign cur_s     = bcd_time_t'(time_cur);
   assign time_next = nxt_s;

   // Ripple the minute carry through the four BCD digits
   always_comb begin
      nxt_s = cur_s;
      if (cur_s.ls_min >= 4'd9) begin
         nxt_s.ls_min = 4'd0;
         if (cur_s.ms_min >= 4'd5) begin
            nxt_s.ms_min = 4'd0;
            if ((cur_s.ms_hour >= 4'd2) && (cur_s.ls_hour >= 4'd3)) begin
               nxt_s.ms_hour = 4'd0;
               nxt_s.ls_hour = 4'd0;
            end else if (cur_s.ls_hour >= 4'd9) begin
               nxt_s.ls_hour = 4'd0;
               nxt_s.ms_hour = cur_s.ms_hour + 4'd1;
            end else begin
               nxt_s.ls_hour = cur_s.ls_hour + 4'd1;
            end
         end else begin
            nxt_s.ms_min = cur_s.ms_min + 4'd1;
         end
      end else begin
         nxt_s.ls_min = cur_s.ls_min + 4'd1;
      end
   end

endmodule

// File: rtl/alarm_time_keeper.sv
// Time-of-day and alarm register keeper with 4-digit keypad entry.
// Feeds current_time, alarm_time and show_alarm to the display driver.
module alarm_time_keeper
   import alarm_clock_pkg::*;
#(
   parameter int          SEC_PER_MIN   = 60,
   parameter int          ENTRY_TIMEOUT = 10,
   parameter logic [15:0] ALARM_RESET   = ALARM_RESET_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        one_second,
   input  logic        key_valid,
   input  logic [3:0]  key,
   input  logic        load_time,
   input  logic        load_alarm,
   input  logic        show_alarm_key,
   output logic [15:0] current_time,
   output logic [15:0] alarm_time,
   output logic [15:0] key_buffer,
   output logic        show_alarm,
   output logic        one_minute,
   output logic        entry_error
);

   localparam int SEC_W = $clog2(SEC_PER_MIN + 1);
   localparam int TO_W  = $clog2(ENTRY_TIMEOUT + 1);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ENTRY_TIMEOUT - 1);

   entry_state_e     state_r,   state_s;
   commit_target_e   target_r,  target_s;
   logic [SEC_W-1:0] sec_cnt_r, sec_cnt_s;
   logic [TO_W-1:0]  to_cnt_r,  to_cnt_s;
   logic [2:0]       key_cnt_r, key_cnt_s;
   logic [15:0]      cur_time_r, cur_time_s;
   logic [15:0]      alarm_r,   alarm_s;
   logic [15:0]      key_buf_r, key_buf_s;
   logic             show_r;
   logic             one_min_r, one_min_s;
   logic             err_r,     err_s;
   logic [15:0]      time_inc_s;
   logic             load_any_s;
   logic             key_ok_s;
   logic             rollover_s;

   bcd_minute_inc u_minute_inc (
      .time_cur  (cur_time_r),
      .time_next (time_inc_s)
   );

   assign load_any_s = load_time | load_alarm;
   assign key_ok_s   = (key <= 4'd9);
   assign rollover_s = one_second && (sec_cnt_r == SEC_LAST);

   // Next-state logic: seconds/minute counting, then entry FSM overrides
   always_comb begin
      state_s    = state_r;
      target_s   = target_r;
      sec_cnt_s  = sec_cnt_r;
      to_cnt_s   = to_cnt_r;
      key_cnt_s  = key_cnt_r;
      cur_time_s = cur_time_r;
      alarm_s    = alarm_r;
      key_buf_s  = key_buf_r;
      one_min_s  = 1'b0;
      err_s      = 1'b0;

      if (rollover_s) begin
         sec_cnt_s  = '0;
         one_min_s  = 1'b1;
         cur_time_s = time_inc_s;
      end else if (one_second) begin
         sec_cnt_s = sec_cnt_r + 1'b1;
      end else begin
         sec_cnt_s = sec_cnt_r;
      end

      case (state_r)
         ST_IDLE: begin
            // A load in IDLE has nothing to commit; a key beside it is dropped
            if (load_any_s) begin
               state_s = ST_IDLE;
            end else if (key_valid) begin
               if (key_ok_s) begin
                  key_buf_s = {key_buf_r[11:0], key};
                  key_cnt_s = 3'd1;
                  to_cnt_s  = '0;
                  state_s   = ST_ENTRY;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ENTRY: begin
            if (load_any_s) begin
               target_s = load_time ? TGT_TIME : TGT_ALARM;
               state_s  = ST_COMMIT;
            end else if (key_valid) begin
               if (key_ok_s) begin
                  key_buf_s = {key_buf_r[11:0], key};
                  key_cnt_s = (key_cnt_r >= 3'd4) ? 3'd4 : key_cnt_r + 3'd1;
                  to_cnt_s  = '0;
               end else begin
                  err_s = 1'b1;
               end
            end else if (one_second) begin
               if (to_cnt_r >= TO_LAST) begin
                  key_buf_s = 16'h0000;
                  key_cnt_s = 3'd0;
                  to_cnt_s  = '0;
                  state_s   = ST_IDLE;
               end else begin
                  to_cnt_s = to_cnt_r + 1'b1;
               end
            end else begin
               state_s = ST_ENTRY;
            end
         end
         ST_COMMIT: begin
            if ((key_cnt_r == 3'd4) && bcd_time_legal(bcd_time_t'(key_buf_r))) begin
               if (target_r == TGT_TIME) begin
                  // Time commit overrides a coincident rollover
                  cur_time_s = key_buf_r;
                  sec_cnt_s  = '0;
                  one_min_s  = 1'b0;
               end else begin
                  alarm_s = key_buf_r;
               end
            end else begin
               err_s = 1'b1;
            end
            key_buf_s = 16'h0000;
            key_cnt_s = 3'd0;
            to_cnt_s  = '0;
            state_s   = ST_IDLE;
         end
         default: begin
            key_buf_s = 16'h0000;
            key_cnt_s = 3'd0;
            to_cnt_s  = '0;
            state_s   = ST_IDLE;
         end
      endcase
   end

   // State and output registers, asynchronously reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         target_r   <= TGT_TIME;
         sec_cnt_r  <= '0;
         to_cnt_r   <= '0;
         key_cnt_r  <= 3'd0;
         cur_time_r <= 16'h0000;
         alarm_r    <= ALARM_RESET;
         key_buf_r  <= 16'h0000;
         show_r     <= 1'b0;
         one_min_r  <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         target_r   <= target_s;
         sec_cnt_r  <= sec_cnt_s;
         to_cnt_r   <= to_cnt_s;
         key_cnt_r  <= key_cnt_s;
         cur_time_r <= cur_time_s;
         alarm_r    <= alarm_s;
         key_buf_r  <= key_buf_s;
         show_r     <= show_alarm_key;
         one_min_r  <= one_min_s;
         err_r      <= err_s;
      end
   end

   assign current_time = cur_time_r;
   assign alarm_time   = alarm_r;
   assign key_buffer   = key_buf_r;
   assign show_alarm   = show_r;
   assign one_minute   = one_min_r;
   assign entry_error  = err_r;

endmodule
